branch_predict_unit: RTL and testbench

- Next-generation RV32/RV64 branch unit: resolves JAL/JALR/BRANCH in execute, and also keeps a direct-mapped BTB with 2-bit saturating counters that predicts fetch PCs.
- Sits between the fetch stage (lookup port) and the execute stage (resolve port).
- Resolve results carry a mispredict/redirect indication to the pipeline flush logic.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/branch_compare.sv | 37 +++
 rtl/branch_predict_unit.sv | 194 +++++++++++++++++++
 tb/tb_branch_predict_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V opcode/func3 constants and branch-unit state encoding.
// Imported by the branch predictor and its comparator.
package riscv_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

endpackage

// File: rtl/branch_compare.sv
// Combinational branch condition evaluation by func3.
// Reserved func3 encodings report illegal and never take.
module branch_compare
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            taken_o,
  output logic            illegal_o
);

  logic eq;
  logic lts;
  logic ltu;

  assign eq  = (rs1_i == rs2_i);
  assign lts = ($signed(rs1_i) < $signed(rs2_i));
  assign ltu = (rs1_i < rs2_i);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (func3_i)
      F3_BEQ:  taken_o = eq;
      F3_BNE:  taken_o = !eq;
      F3_BLT:  taken_o = lts;
      F3_BGE:  taken_o = !lts;
      F3_BLTU: taken_o = ltu;
      F3_BGEU: taken_o = !ltu;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolve unit plus direct-mapped BTB with 2-bit counters.
// Fetch lookups and execute resolves both have one-cycle latency.
module branch_predict_unit
  import riscv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 64,
  localparam int IDX_W      = $clog2(BTB_ENTRIES),
  localparam int TAG_W      = XLEN - IDX_W - 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ready,
  input  logic            f_valid,
  input  logic [XLEN-1:0] f_pc,
  output logic            p_valid,
  output logic            p_taken,
  output logic [XLEN-1:0] p_target,
  input  logic            ex_valid,
  input  logic [6:0]      ex_opcode,
  input  logic [2:0]      ex_func3,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            r_valid,
  output logic            r_taken,
  output logic [XLEN-1:0] r_target,
  output logic [XLEN-1:0] r_link,
  output logic            r_mispredict,
  output logic [XLEN-1:0] r_redirect_pc,
  output logic            r_illegal
);

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);
  localparam logic [XLEN-1:0] ONE  = XLEN'(1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BTB_ENTRIES - 1);

  state_e           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic             ready_q;

  logic             valid_q  [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]  target_q [BTB_ENTRIES];
  logic             jump_q   [BTB_ENTRIES];
  logic [1:0]       cnt_q    [BTB_ENTRIES];

  logic            p_valid_q, p_taken_q;
  logic [XLEN-1:0] p_target_q;
  logic            r_valid_q, r_taken_q, r_mis_q, r_ill_q;
  logic [XLEN-1:0] r_target_q, r_link_q, r_redir_q;

  // Fetch-side lookup
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic             f_taken_d;
  logic [XLEN-1:0]  f_target_d;

  assign f_idx = f_pc[IDX_W+1:2];
  assign f_tag = f_pc[XLEN-1:IDX_W+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign f_taken_d = (state_q == ST_READY) && f_hit
                  && (jump_q[f_idx] || cnt_q[f_idx][1]);
  assign f_target_d = f_taken_d ? target_q[f_idx] : f_pc + FOUR;

  // Execute-side resolve
  logic            is_jal, is_jalr, is_br;
  logic            cmp_taken, cmp_ill;
  logic            rv_d, tk_d, ill_d, mis_d;
  logic [XLEN-1:0] jalr_sum, tgt_d, link_d, redir_d;

  assign is_jal  = (ex_opcode == OP_JAL);
  assign is_jalr = (ex_opcode == OP_JALR);
  assign is_br   = (ex_opcode == OP_BRANCH);

  branch_compare #(.XLEN(XLEN)) u_cmp (
    .func3_i   (ex_func3),
    .rs1_i     (ex_rs1),
    .rs2_i     (ex_rs2),
    .taken_o   (cmp_taken),
    .illegal_o (cmp_ill)
  );

  assign jalr_sum = ex_rs1 + ex_imm;
  assign tgt_d    = is_jalr ? (jalr_sum & ~ONE) : ex_pc + ex_imm;
  assign link_d   = ex_pc + FOUR;
  assign rv_d     = ex_valid && (is_jal || is_jalr || is_br);
  assign tk_d     = is_jal || is_jalr || (is_br && cmp_taken);
  assign ill_d    = is_br && cmp_ill;
  assign mis_d    = (tk_d != ex_pred_taken)
                 || (tk_d && (ex_pred_target != tgt_d));
  assign redir_d  = tk_d ? tgt_d : link_d;

  // Table update
  logic [IDX_W-1:0] e_idx;
  logic [TAG_W-1:0] e_tag;
  logic             e_hit;
  logic             upd_en;
  logic [1:0]       e_cnt, cnt_d;

  assign e_idx  = ex_pc[IDX_W+1:2];
  assign e_tag  = ex_pc[XLEN-1:IDX_W+2];
  assign e_hit  = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign upd_en = !reset && (state_q == ST_READY) && rv_d && !ill_d;
  assign e_cnt  = cnt_q[e_idx];

  always_comb begin
    cnt_d = e_cnt;
    if (tk_d && e_cnt != 2'b11) cnt_d = e_cnt + 2'b01;
    if (!tk_d && e_cnt != 2'b00) cnt_d = e_cnt - 2'b01;
  end

  // Arrays carry no reset; the INIT sweep establishes their contents
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      valid_q[ptr_q] <= 1'b0;
      cnt_q[ptr_q]   <= 2'b01;
    end else if (upd_en) begin
      if (e_hit && is_br) begin
        cnt_q[e_idx] <= cnt_d;
        if (tk_d) target_q[e_idx] <= tgt_d;
      end else if (e_hit) begin
        target_q[e_idx] <= tgt_d;
        jump_q[e_idx]   <= 1'b1;
        cnt_q[e_idx]    <= 2'b11;
      end else if (tk_d) begin
        valid_q[e_idx]  <= 1'b1;
        tag_q[e_idx]    <= e_tag;
        target_q[e_idx] <= tgt_d;
        jump_q[e_idx]   <= !is_br;
        cnt_q[e_idx]    <= is_br ? 2'b10 : 2'b11;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      ptr_q      <= '0;
      ready_q    <= 1'b0;
      p_valid_q  <= 1'b0;
      p_taken_q  <= 1'b0;
      p_target_q <= '0;
      r_valid_q  <= 1'b0;
      r_taken_q  <= 1'b0;
      r_target_q <= '0;
      r_link_q   <= '0;
      r_mis_q    <= 1'b0;
      r_redir_q  <= '0;
      r_ill_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == LAST) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_READY;
          ready_q <= 1'b1;
        end
      endcase
      p_valid_q  <= f_valid;
      p_taken_q  <= f_taken_d;
      p_target_q <= f_target_d;
      r_valid_q  <= rv_d;
      r_taken_q  <= rv_d && tk_d;
      r_target_q <= rv_d ? tgt_d : '0;
      r_link_q   <= rv_d ? link_d : '0;
      r_mis_q    <= rv_d && mis_d;
      r_redir_q  <= rv_d ? redir_d : '0;
      r_ill_q    <= rv_d && ill_d;
    end
  end

  assign ready         = ready_q;
  assign p_valid       = p_valid_q;
  assign p_taken       = p_taken_q;
  assign p_target      = p_target_q;
  assign r_valid       = r_valid_q;
  assign r_taken       = r_taken_q;
  assign r_target      = r_target_q;
  assign r_link        = r_link_q;
  assign r_mispredict  = r_mis_q;
  assign r_redirect_pc = r_redir_q;
  assign r_illegal     = r_ill_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: directed lookups and
// resolves, expected responses queued at issue and checked by a monitor.
module tb_branch_predict_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic        f_valid;
  logic [31:0] f_pc;
  logic        p_valid, p_taken;
  logic [31:0] p_target;
  logic        ex_valid;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_func3;
  logic [31:0] ex_imm, ex_pc, ex_rs1, ex_rs2;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        r_valid, r_taken, r_mispredict, r_illegal;
  logic [31:0] r_target, r_link, r_redirect_pc;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        t;
    logic [31:0] tg;
  } lk_t;

  typedef struct packed {
    logic        t;
    logic [31:0] tg;
    logic [31:0] ln;
    logic        mis;
    logic [31:0] rd;
    logic        il;
  } rs_t;

  lk_t lq[$];
  rs_t rq[$];

  branch_predict_unit #(.XLEN(32), .BTB_ENTRIES(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .ready          (ready),
    .f_valid        (f_valid),
    .f_pc           (f_pc),
    .p_valid        (p_valid),
    .p_taken        (p_taken),
    .p_target       (p_target),
    .ex_valid       (ex_valid),
    .ex_opcode      (ex_opcode),
    .ex_func3       (ex_func3),
    .ex_imm         (ex_imm),
    .ex_pc          (ex_pc),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .r_valid        (r_valid),
    .r_taken        (r_taken),
    .r_target       (r_target),
    .r_link         (r_link),
    .r_mispredict   (r_mispredict),
    .r_redirect_pc  (r_redirect_pc),
    .r_illegal      (r_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    f_valid  = 1'b0;
    ex_valid = 1'b0;
  endtask

  task automatic lk(input logic [31:0] pc, input logic et,
                    input logic [31:0] etg);
    f_valid = 1'b1;
    f_pc    = pc;
    lq.push_back({et, etg});
  endtask

  task automatic rs(input logic [6:0] op, input logic [2:0] f3,
                    input logic [31:0] pc, input logic [31:0] imm,
                    input logic [31:0] a, input logic [31:0] b,
                    input logic pt, input logic [31:0] ptg,
                    input logic et, input logic [31:0] etg,
                    input logic em, input logic [31:0] erd,
                    input logic eil);
    ex_valid       = 1'b1;
    ex_opcode      = op;
    ex_func3       = f3;
    ex_pc          = pc;
    ex_imm         = imm;
    ex_rs1         = a;
    ex_rs2         = b;
    ex_pred_taken  = pt;
    ex_pred_target = ptg;
    rq.push_back({et, etg, pc + 32'd4, em, erd, eil});
  endtask

  // Monitor: pops an expectation whenever the DUT presents a result
  always @(negedge clk) begin
    if (p_valid) begin
      total++;
      if (lq.size() == 0) begin
        bad++;
        $display("FAIL lookup: unexpected p_valid pc-target %h", p_target);
      end else begin
        lk_t e;
        e = lq.pop_front();
        if (p_taken !== e.t || p_target !== e.tg) begin
          bad++;
          $display("FAIL lookup: got taken=%b target=%h expected taken=%b target=%h",
                   p_taken, p_target, e.t, e.tg);
        end
      end
    end
    if (r_valid) begin
      total++;
      if (rq.size() == 0) begin
        bad++;
        $display("FAIL resolve: unexpected r_valid target %h", r_target);
      end else begin
        rs_t e;
        e = rq.pop_front();
        if (r_taken !== e.t || r_target !== e.tg || r_link !== e.ln ||
            r_mispredict !== e.mis || r_redirect_pc !== e.rd ||
            r_illegal !== e.il) begin
          bad++;
          $display("FAIL resolve: got t=%b tg=%h ln=%h mis=%b rd=%h il=%b expected t=%b tg=%h ln=%h mis=%b rd=%h il=%b",
                   r_taken, r_target, r_link, r_mispredict, r_redirect_pc,
                   r_illegal, e.t, e.tg, e.ln, e.mis, e.rd, e.il);
        end
      end
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, " ready"}, 32'(ready), 32'd0);
    chk({nm, " p_valid"}, {29'd0, p_valid, p_taken, r_valid}, 32'd0);
    chk({nm, " p_target"}, p_target, 32'd0);
    chk({nm, " r_target"}, r_target, 32'd0);
    chk({nm, " r_link"}, r_link, 32'd0);
    chk({nm, " r_flags"}, {29'd0, r_taken, r_mispredict, r_illegal}, 32'd0);
    chk({nm, " r_redirect"}, r_redirect_pc, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    f_valid = 1'b0; f_pc = '0;
    ex_valid = 1'b0; ex_opcode = '0; ex_func3 = '0; ex_imm = '0;
    ex_pc = '0; ex_rs1 = '0; ex_rs2 = '0;
    ex_pred_taken = 1'b0; ex_pred_target = '0;
    repeat (3) tick();
    chk_zero("reset");

    // Init sweep with a lookup and a JAL resolve in flight
    reset = 1'b0;
    for (int n = 1; n <= 64; n++) begin
      if (n == 10) lk(32'h100, 1'b0, 32'h104);
      if (n == 20)
        rs(OP_JAL, 3'b000, 32'h1C0, 32'h10, 0, 0, 1'b0, 0,
           1'b1, 32'h1D0, 1'b1, 32'h1D0, 1'b0);
      tick();
      chk($sformatf("ready n=%0d", n), 32'(ready), 32'(n == 64));
    end

    // Resolve during INIT did not allocate
    lk(32'h1C0, 1'b0, 32'h1C4); tick();

    // BEQ taken, allocate, then predicted taken
    rs(OP_BRANCH, F3_BEQ, 32'h100, 32'h40, 5, 5, 1'b0, 0,
       1'b1, 32'h140, 1'b1, 32'h140, 1'b0); tick();
    lk(32'h100, 1'b1, 32'h140); tick();

    // Three not-taken: counter 2->1->0->0
    repeat (3) begin
      rs(OP_BRANCH, F3_BEQ, 32'h100, 32'h40, 5, 6, 1'b1, 32'h140,
         1'b0, 32'h140, 1'b1, 32'h104, 1'b0); tick();
    end
    lk(32'h100, 1'b0, 32'h104); tick();
    rs(OP_BRANCH, F3_BEQ, 32'h100, 32'h40, 5, 5, 1'b0, 0,
       1'b1, 32'h140, 1'b1, 32'h140, 1'b0); tick();
    lk(32'h100, 1'b0, 32'h104); tick();
    rs(OP_BRANCH, F3_BEQ, 32'h100, 32'h40, 5, 5, 1'b0, 0,
       1'b1, 32'h140, 1'b1, 32'h140, 1'b0); tick();
    lk(32'h100, 1'b1, 32'h140); tick();

    // Compare flavours
    rs(OP_BRANCH, F3_BLT, 32'h304, 32'h20, 32'hFFFFFFFF, 1, 1'b0, 0,
       1'b1, 32'h324, 1'b1, 32'h324, 1'b0); tick();
    rs(OP_BRANCH, F3_BLTU, 32'h408, 32'h20, 32'hFFFFFFFF, 1, 1'b0, 0,
       1'b0, 32'h428, 1'b0, 32'h40C, 1'b0); tick();
    rs(OP_BRANCH, F3_BGE, 32'h50C, 32'h20, 7, 7, 1'b1, 32'h52C,
       1'b1, 32'h52C, 1'b0, 32'h52C, 1'b0); tick();
    rs(OP_BRANCH, F3_BNE, 32'h618, 32'h10, 1, 2, 1'b1, 32'h999,
       1'b1, 32'h628, 1'b1, 32'h628, 1'b0); tick();
    rs(OP_BRANCH, F3_BGEU, 32'h620, 32'h10, 1, 32'hFFFFFFFF, 1'b0, 0,
       1'b0, 32'h630, 1'b0, 32'h624, 1'b0); tick();
    rs(OP_BRANCH, 3'b010, 32'h724, 32'h40, 0, 0, 1'b0, 0,
       1'b0, 32'h764, 1'b0, 32'h728, 1'b1); tick();
    rs(OP_BRANCH, 3'b011, 32'h304, 32'h40, 0, 0, 1'b1, 32'h324,
       1'b0, 32'h344, 1'b1, 32'h308, 1'b1); tick();
    ex_valid = 1'b1; ex_opcode = 7'b0110011; ex_pc = 32'h800; tick();
    lk(32'h304, 1'b1, 32'h324); tick();
    lk(32'h408, 1'b0, 32'h40C); tick();
    lk(32'h50C, 1'b1, 32'h52C); tick();
    lk(32'h618, 1'b1, 32'h628); tick();
    lk(32'h724, 1'b0, 32'h728); tick();
    lk(32'h800, 1'b0, 32'h804); tick();

    // JALR target clears bit 0; retarget on second resolve
    rs(OP_JALR, 3'b000, 32'h80, 32'hFFFFFFFE, 32'h2001, 0, 1'b0, 0,
       1'b1, 32'h1FFE, 1'b1, 32'h1FFE, 1'b0); tick();
    lk(32'h80, 1'b1, 32'h1FFE); tick();
    rs(OP_JALR, 3'b000, 32'h80, 32'h0, 32'h3000, 0, 1'b1, 32'h1FFE,
       1'b1, 32'h3000, 1'b1, 32'h3000, 1'b0); tick();
    lk(32'h80, 1'b1, 32'h3000); tick();

    // Wrapping JAL
    rs(OP_JAL, 3'b000, 32'hFFFFFFF0, 32'h20, 0, 0, 1'b0, 0,
       1'b1, 32'h10, 1'b1, 32'h10, 1'b0); tick();

    // Same-cycle lookup/update of index 5 reads old entry
    rs(OP_JAL, 3'b000, 32'h14, 32'h100, 0, 0, 1'b0, 0,
       1'b1, 32'h114, 1'b1, 32'h114, 1'b0); tick();
    lk(32'h14, 1'b1, 32'h114);
    rs(OP_JAL, 3'b000, 32'h14, 32'h200, 0, 0, 1'b1, 32'h114,
       1'b1, 32'h214, 1'b1, 32'h214, 1'b0); tick();
    lk(32'h14, 1'b1, 32'h214); tick();

    // Reset mid-stream drops in-flight requests
    f_valid = 1'b1; f_pc = 32'h14;
    ex_valid = 1'b1; ex_opcode = OP_JAL; ex_pc = 32'h14; ex_imm = 32'h8;
    reset = 1'b1; tick();
    chk_zero("midreset");
    tick();
    reset = 1'b0;
    for (int n = 1; n <= 64; n++) begin
      if (n == 3) lk(32'h14, 1'b0, 32'h18);
      tick();
      chk($sformatf("ready2 n=%0d", n), 32'(ready), 32'(n == 64));
    end
    lk(32'h14, 1'b0, 32'h18); tick();
    lk(32'h80, 1'b0, 32'h84); tick();
    lk(32'h100, 1'b0, 32'h104); tick();
    repeat (3) tick();

    chk("lookup queue drained", 32'(lq.size()), 32'd0);
    chk("resolve queue drained", 32'(rq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
